// File: rtl/uart_char_writer.sv
// Terminal-style character writer: turns received UART bytes into frame-buffer
// writes, keeps a text cursor, and clears the screen after reset and on form feed.
module uart_char_writer #(
   parameter  int COLS   = 80,
   parameter  int ROWS   = 30,
   parameter  int ADDR_W = 12,
   localparam int COL_W  = $clog2(COLS),
   localparam int ROW_W  = $clog2(ROWS)
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   input  logic              i_RX_DV,
   input  logic [7:0]        i_RX_Byte,
   output logic              o_Wr_En,
   output logic [ADDR_W-1:0] o_Wr_Addr,
   output logic [7:0]        o_Wr_Data,
   output logic [COL_W-1:0]  o_Cursor_Col,
   output logic [ROW_W-1:0]  o_Cursor_Row,
   output logic              o_Busy,
   output logic              o_Overrun
);

   localparam logic [ADDR_W:0]   CELLS   = (ADDR_W+1)'(COLS * ROWS);
   localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
   localparam logic [COL_W-1:0]  COL_MAX = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(ROWS - 1);
   localparam logic [7:0]        SPACE   = 8'h20;

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   state_t              state, state_n;
   logic [ADDR_W:0]     sweep, sweep_n;   // one extra bit so the terminal count always fits
   logic                pend, pend_n;
   logic [7:0]          pend_byte, pend_byte_n;
   logic                wr_en_n;
   logic [ADDR_W-1:0]   wr_addr_n;
   logic [7:0]          wr_data_n;
   logic [COL_W-1:0]    col_n;
   logic [ROW_W-1:0]    row_n;
   logic                busy_n, overrun_n;

   logic [7:0]          byte_sel;
   logic [ADDR_W-1:0]   cur_addr;
   logic [ROW_W-1:0]    row_adv;

   // Cursor-derived helpers: linear address and wrapped next row
   always_comb begin
      byte_sel = pend ? pend_byte : i_RX_Byte;
      cur_addr = ADDR_W'(o_Cursor_Row) * COLS_A + ADDR_W'(o_Cursor_Col);
      row_adv  = (o_Cursor_Row == ROW_MAX) ? '0 : o_Cursor_Row + 1'b1;
   end

   // Next-state and registered-output logic
   always_comb begin
      state_n     = state;
      sweep_n     = sweep;
      pend_n      = pend;
      pend_byte_n = pend_byte;
      wr_en_n     = 1'b0;
      wr_addr_n   = o_Wr_Addr;
      wr_data_n   = o_Wr_Data;
      col_n       = o_Cursor_Col;
      row_n       = o_Cursor_Row;
      busy_n      = o_Busy;
      overrun_n   = o_Overrun;

      case (state)
         ST_CLEAR: begin
            // Terminal count is a write-free cycle, so o_Busy drops one cycle after the last write
            if (sweep == CELLS) begin
               state_n = ST_IDLE;
               busy_n  = 1'b0;
               col_n   = '0;
               row_n   = '0;
            end else begin
               wr_en_n   = 1'b1;
               wr_addr_n = sweep[ADDR_W-1:0];
               wr_data_n = SPACE;
               sweep_n   = sweep + 1'b1;
            end
            if (i_RX_DV) begin
               if (pend) begin
                  overrun_n = 1'b1;
               end else begin
                  pend_n      = 1'b1;
                  pend_byte_n = i_RX_Byte;
               end
            end
         end

         ST_IDLE: begin
            if (pend || i_RX_DV) begin
               // Held byte is served first; a byte arriving alongside it takes the holding slot
               if (pend) begin
                  pend_n = i_RX_DV;
                  if (i_RX_DV) pend_byte_n = i_RX_Byte;
               end
               if (byte_sel >= 8'h20 && byte_sel <= 8'h7E) begin
                  wr_en_n   = 1'b1;
                  wr_addr_n = cur_addr;
                  wr_data_n = byte_sel;
                  if (o_Cursor_Col == COL_MAX) begin
                     col_n = '0;
                     row_n = row_adv;
                  end else begin
                     col_n = o_Cursor_Col + 1'b1;
                  end
               end else begin
                  case (byte_sel)
                     8'h0D: col_n = '0;
                     8'h0A: row_n = row_adv;
                     8'h08: begin
                        if (o_Cursor_Col != '0) begin
                           col_n     = o_Cursor_Col - 1'b1;
                           wr_en_n   = 1'b1;
                           wr_addr_n = cur_addr - 1'b1;
                           wr_data_n = SPACE;
                        end
                     end
                     8'h0C: begin
                        // Address 0 is written in this same step so the sweep starts next cycle
                        state_n   = ST_CLEAR;
                        busy_n    = 1'b1;
                        col_n     = '0;
                        row_n     = '0;
                        wr_en_n   = 1'b1;
                        wr_addr_n = '0;
                        wr_data_n = SPACE;
                        sweep_n   = (ADDR_W+1)'(1);
                     end
                     default: ;
                  endcase
               end
            end
         end

         default: state_n = ST_CLEAR;
      endcase
   end

   // State and output registers with asynchronous reset into a fresh clear sweep
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state        <= ST_CLEAR;
         sweep        <= '0;
         pend         <= 1'b0;
         pend_byte    <= '0;
         o_Wr_En      <= 1'b0;
         o_Wr_Addr    <= '0;
         o_Wr_Data    <= SPACE;
         o_Cursor_Col <= '0;
         o_Cursor_Row <= '0;
         o_Busy       <= 1'b1;
         o_Overrun    <= 1'b0;
      end else begin
         state        <= state_n;
         sweep        <= sweep_n;
         pend         <= pend_n;
         pend_byte    <= pend_byte_n;
         o_Wr_En      <= wr_en_n;
         o_Wr_Addr    <= wr_addr_n;
         o_Wr_Data    <= wr_data_n;
         o_Cursor_Col <= col_n;
         o_Cursor_Row <= row_n;
         o_Busy       <= busy_n;
         o_Overrun    <= overrun_n;
      end
   end

endmodule

// File: tb/tb_uart_char_writer.sv
// Scoreboard bench for uart_char_writer: a terminal model predicts every
// frame-buffer write; a monitor pops and compares each write the DUT makes.
module tb_uart_char_writer;

   localparam int COLS   = 80;
   localparam int ROWS   = 30;
   localparam int ADDR_W = 12;
   localparam int CELLS  = COLS * ROWS;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              dv = 1'b0;
   logic [7:0]        rx_byte = 8'h00;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic [6:0]        cur_col;
   logic [4:0]        cur_row;
   logic              busy;
   logic              overrun;

   uart_char_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
      .i_Clk        (clk),
      .i_Rst        (rst),
      .i_RX_DV      (dv),
      .i_RX_Byte    (rx_byte),
      .o_Wr_En      (wr_en),
      .o_Wr_Addr    (wr_addr),
      .o_Wr_Data    (wr_data),
      .o_Cursor_Col (cur_col),
      .o_Cursor_Row (cur_row),
      .o_Busy       (busy),
      .o_Overrun    (overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [7:0]        d;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  checks = 0;
   int  errors = 0;

   // Terminal model state
   int  mcol = 0;
   int  mrow = 0;
   int  held = -1;
   bit  in_sweep = 1'b1;
   bit  exp_ovr = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic push_wr(input int addr, input int data);
      wr_t w;
      w.a = ADDR_W'(addr);
      w.d = 8'(data);
      exp_q.push_back(w);
   endtask

   task automatic push_sweep();
      for (int i = 0; i < CELLS; i++) push_wr(i, 8'h20);
   endtask

   // Terminal semantics: returns whether the byte produces a write
   task automatic model_apply(input logic [7:0] b, output bit wr);
      wr = 1'b0;
      if (b >= 8'h20 && b <= 8'h7E) begin
         push_wr(mrow * COLS + mcol, b);
         wr = 1'b1;
         mcol++;
         if (mcol == COLS) begin
            mcol = 0;
            mrow = (mrow + 1) % ROWS;
         end
      end else begin
         case (b)
            8'h0D: mcol = 0;
            8'h0A: mrow = (mrow + 1) % ROWS;
            8'h08: if (mcol > 0) begin
               mcol--;
               push_wr(mrow * COLS + mcol, 8'h20);
               wr = 1'b1;
            end
            8'h0C: begin
               mcol = 0;
               mrow = 0;
               push_sweep();
               in_sweep = 1'b1;
               wr = 1'b1;
            end
            default: ;
         endcase
      end
   endtask

   task automatic check_cursor(input string tag);
      check({tag, "_col"}, 32'(cur_col), 32'(mcol));
      check({tag, "_row"}, 32'(cur_row), 32'(mrow));
   endtask

   task automatic check_reset_values();
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_wr_addr", 32'(wr_addr), 0);
      check("rst_wr_data", 32'(wr_data), 32'h20);
      check("rst_col", 32'(cur_col), 0);
      check("rst_row", 32'(cur_row), 0);
      check("rst_busy", 32'(busy), 1);
      check("rst_overrun", 32'(overrun), 0);
   endtask

   // One-cycle DV pulse; outputs are checked just after the capturing edge
   task automatic send(input logic [7:0] b);
      bit wr_exp;
      @(posedge clk); #1;
      dv = 1'b1;
      rx_byte = b;
      @(posedge clk); #1;
      dv = 1'b0;
      if (in_sweep) begin
         if (held < 0) held = int'(b);
         else exp_ovr = 1'b1;
         wr_exp = 1'b1;
      end else begin
         model_apply(b, wr_exp);
      end
      check("byte_wr_en", 32'(wr_en), 32'(wr_exp));
      check("byte_busy", 32'(busy), 32'(in_sweep));
      check("byte_overrun", 32'(overrun), 32'(exp_ovr));
      check_cursor("byte");
   endtask

   // Bounded wait for the sweep to end; a held byte must write on the next cycle
   task automatic wait_idle(input int exp_n);
      int n;
      bit w;
      n = 0;
      while (busy === 1'b1 && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      check("sweep_done", 32'(busy), 0);
      if (exp_n >= 0) check("sweep_cycles", 32'(n), 32'(exp_n));
      in_sweep = 1'b0;
      check_cursor("post_sweep");
      if (held >= 0) begin
         model_apply(8'(held), w);
         held = -1;
         @(posedge clk); #1;
         check("held_wr_en", 32'(wr_en), 32'(w));
         check_cursor("held");
      end
   endtask

   task automatic random_bytes(input int count);
      logic [7:0] b;
      for (int k = 0; k < count; k++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: b = 8'($urandom_range(32, 126));
            6: b = 8'h0D;
            7: b = 8'h0A;
            8: b = 8'h08;
            default: b = 8'($urandom_range(0, 255));
         endcase
         if (b == 8'h0C) b = 8'h41;
         send(b);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
   endtask

   // Scoreboard monitor: every DUT write must match the next predicted write
   always @(negedge clk) begin
      if (!rst && wr_en === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", wr_addr, wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (wr_addr !== mon_e.a || wr_data !== mon_e.d) begin
               errors++;
               $display("FAIL write: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                        wr_addr, wr_data, mon_e.a, mon_e.d);
            end
         end
      end
   end

   initial begin
      // Reset and initial clear sweep
      repeat (3) @(posedge clk); #1;
      check_reset_values();
      push_sweep();
      in_sweep = 1'b1;
      rst = 1'b0;
      wait_idle(CELLS + 1);

      // Directed text, wrapping and control codes
      send(8'h41);
      check("A_col", 32'(cur_col), 1);
      check("A_addr", 32'(wr_addr), 0);
      send(8'h0D);
      repeat (COLS) send(8'h78);
      check("line_wrap_col", 32'(cur_col), 0);
      check("line_wrap_row", 32'(cur_row), 1);
      send(8'h0D);
      send(8'h0A);
      send(8'h42);
      check("B_addr", 32'(wr_addr), 160);
      check("B_row", 32'(cur_row), 2);
      repeat (27) send(8'h0A);
      check("row_29", 32'(cur_row), 29);
      send(8'h0A);
      check("row_wrap", 32'(cur_row), 0);
      send(8'h0D);
      send(8'h08);
      check("bs_col0_col", 32'(cur_col), 0);
      repeat (5) send(8'h6B);
      send(8'h08);
      check("bs_addr", 32'(wr_addr), 4);
      check("bs_data", 32'(wr_data), 32'h20);
      check("bs_col", 32'(cur_col), 4);
      send(8'h7F);
      send(8'h01);

      random_bytes(200);

      // Form feed with one byte arriving mid-sweep
      send(8'h0C);
      repeat (100) @(posedge clk);
      send(8'h5A);
      wait_idle(-1);
      check("Z_addr", 32'(wr_addr), 0);
      check("Z_data", 32'(wr_data), 32'h5A);
      check("Z_overrun", 32'(overrun), 0);

      // Two bytes in one sweep: second is lost, overrun sticks
      send(8'h0C);
      repeat (50) @(posedge clk);
      send(8'h50);
      repeat (50) @(posedge clk);
      send(8'h51);
      wait_idle(-1);
      check("ovr_data", 32'(wr_data), 32'h50);
      check("ovr_sticky", 32'(overrun), 1);

      random_bytes(100);

      // Reset asserted in the middle of a sweep
      send(8'h0C);
      repeat (300) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_reset_values();
      exp_q.delete();
      mcol = 0;
      mrow = 0;
      held = -1;
      exp_ovr = 1'b0;
      in_sweep = 1'b1;
      repeat (2) @(posedge clk); #1;
      check_reset_values();
      push_sweep();
      rst = 1'b0;
      wait_idle(CELLS + 1);
      send(8'h45);
      repeat (4) @(posedge clk);
      check("queue_empty", 32'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_char_writer.md
# uart_char_writer

Terminal-style character writer sitting directly downstream of the UART receiver. Consumes each received byte (single-cycle valid pulse plus 8-bit data) and turns it into a write into the VGA character frame buffer. Maintains a text cursor and interprets a small set of control codes. Clears the whole screen after reset and on form feed.

## Interface
- COLS, 80, characters per row
- ROWS, 30, character rows
- ADDR_W, 12, frame-buffer address width; must satisfy 2^ADDR_W ≥ COLS*ROWS
- i_Clk  in  1  system clock (same clock as the UART receiver)
- i_Rst  in  1  reset; asynchronous, active-high
- i_RX_DV  in  1  one-cycle pulse: i_RX_Byte valid
- i_RX_Byte  in  8  received byte
- o_Wr_En  out  1  frame-buffer write strobe, one cycle per write
- o_Wr_Addr  out  ADDR_W  write address = row*COLS + col
- o_Wr_Data  out  8  character code to write
- o_Cursor_Col  out  clog2(COLS)  current cursor column
- o_Cursor_Row  out  clog2(ROWS)  current cursor row
- o_Busy  out  1  high while a clear sweep is in progress
- o_Overrun  out  1  sticky: a byte was lost; cleared only by reset

## Operation
- States: CLEAR, IDLE. All outputs are registered.
- Reset values: o_Wr_En=0, o_Wr_Addr=0, o_Wr_Data=0x20, cursor (0,0), o_Busy=1, o_Overrun=0, pending flag=0. State is CLEAR with sweep counter 0.
- CLEAR: each cycle, write 0x20 to address = sweep counter, then increment. After writing COLS*ROWS-1: state → IDLE, o_Busy=0, cursor (0,0).
- IDLE, i_RX_DV=1, byte decode:
  - 0x20–0x7E: write the byte at the cursor, then advance col. If col was COLS-1, col=0 and row advances.
  - 0x0D (CR): col=0, no write.
  - 0x0A (LF): row advances, col unchanged, no write.
  - 0x08 (BS): if col>0, col-1 and write 0x20 at the new position. At col 0, no action.
  - 0x0C (FF): cursor (0,0), counter 0, state → CLEAR, o_Busy=1.
  - All other bytes: ignored, no write, cursor unchanged.
- Row advance from ROWS-1 wraps to 0. There is no scrolling.
- Pending byte: i_RX_DV during CLEAR latches the byte into a one-entry holding register and sets the pending flag. On the first IDLE cycle, the held byte is processed exactly as above and the flag clears.
- Overrun: i_RX_DV while the pending flag is already set drops the new byte and sets o_Overrun. The held byte is kept.
- Reset asserted mid-operation: all state returns to reset values immediately, and a new clear sweep starts.

## Timing
- IDLE byte processing: i_RX_DV at cycle N → o_Wr_En, o_Wr_Addr, o_Wr_Data valid in cycle N+1. Cursor outputs show the post-update position from cycle N+1.
- o_Wr_En is high for exactly one cycle per written character.
- Clear sweep: COLS*ROWS consecutive cycles with o_Wr_En=1 (2400 at defaults), addresses 0..2399 in order. o_Busy falls on the cycle after the last write.
- Pending byte: its write appears on the cycle after o_Busy falls.
- FF received in IDLE at cycle N: first sweep write (address 0) occurs in cycle N+1.
- Input rate is at most one byte per 8680 clocks at 115200 baud, 100 MHz, so a sweep (2400 cycles) holds at most one byte. Overrun only occurs if a sweep exceeds one byte time.
- Address arithmetic is exact and unsigned. A running address register or a multiply is allowed, provided o_Wr_Addr = row*COLS + col at every write.

## Test plan
- Reset release: 2400 writes of 0x20 to addresses 0..2399 with o_Busy=1, then o_Busy=0 and cursor (0,0).
- Send 'A' (0x41) in IDLE: one write, addr 0, data 0x41; cursor (1,0).
- Send 80 × 'x': last write at addr 79, cursor (0,1). Then CR, LF, 'B': write addr 160, cursor (1,2). Row wrap: from row 29, LF → row 0.
- Backspace at col 0: no write, cursor unchanged. At col 5: write 0x20 to addr row*80+4, cursor col 4.
- FF, then 'Z' 100 cycles later: 'Z' held during the sweep, then written at addr 0 one cycle after o_Busy falls; o_Overrun stays 0. Two bytes during one sweep: o_Overrun=1, first byte written, second byte lost.
- Unprintable 0x7F and 0x01: no write, cursor unchanged. Assert i_Rst mid-sweep: outputs return to reset values at once, and the sweep restarts from address 0.
